div5_serial_checker: RTL and testbench

- Sequential front end for the divisible-by-5 check.
- Accepts a WIDTH-bit operand over a valid/ready handshake.
- Serially reduces the operand MSB-first with a mod-5 remainder state machine, one bit per clock.
- Presents the remainder and a divisibility flag on a valid/ready output to the downstream reporting stage.

---
 rtl/div5_serial_checker.sv | 117 +++++++++++
 tb/tb_div5_serial_checker.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/div5_serial_checker.sv
// Serial divisible-by-5 front end: takes an operand over valid/ready, reduces it
// MSB-first through a mod-5 remainder recurrence, and presents the result on valid/ready.
module div5_serial_checker #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned CNT_W = 6
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [2:0]       out_rem,
   output logic             out_div5,
   output logic             busy
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   shreg_q, shreg_d;
   logic [WIDTH-1:0]   out_data_q, out_data_d;
   logic [2:0]         rem_q, rem_d;
   logic [2:0]         out_rem_q, out_rem_d;
   logic               out_div5_q, out_div5_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;

   // 2*rem+b is at most 9, so one conditional subtract of 5 completes the reduction
   logic [3:0]         dbl;
   logic [3:0]         dbl_red;
   logic [2:0]         rem_step;

   always_comb begin
      dbl      = {rem_q, shreg_q[WIDTH-1]};
      dbl_red  = (dbl >= 4'd5) ? (dbl - 4'd5) : dbl;
      rem_step = dbl_red[2:0];
   end

   always_comb begin
      state_d    = state_q;
      shreg_d    = shreg_q;
      out_data_d = out_data_q;
      rem_d      = rem_q;
      out_rem_d  = out_rem_q;
      out_div5_d = out_div5_q;
      cnt_d      = cnt_q;
      in_ready   = 1'b0;
      out_valid  = 1'b0;
      busy       = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               shreg_d    = in_data;
               out_data_d = in_data;
               rem_d      = '0;
               cnt_d      = CNT_W'(WIDTH);
               state_d    = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            busy    = 1'b1;
            rem_d   = rem_step;
            shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
            cnt_d   = cnt_q - 1'b1;
            // Result registers load only on the last step so they hold between operands
            if (cnt_q == CNT_W'(1)) begin
               out_rem_d  = rem_step;
               out_div5_d = (rem_step == 3'd0);
               state_d    = ST_DONE;
            end
         end
         ST_DONE: begin
            busy      = 1'b1;
            out_valid = 1'b1;
            if (out_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         shreg_q    <= '0;
         out_data_q <= '0;
         rem_q      <= '0;
         out_rem_q  <= '0;
         out_div5_q <= 1'b0;
         cnt_q      <= '0;
      end else begin
         state_q    <= state_d;
         shreg_q    <= shreg_d;
         out_data_q <= out_data_d;
         rem_q      <= rem_d;
         out_rem_q  <= out_rem_d;
         out_div5_q <= out_div5_d;
         cnt_q      <= cnt_d;
      end
   end

   assign out_data = out_data_q;
   assign out_rem  = out_rem_q;
   assign out_div5 = out_div5_q;

endmodule

// File: tb/tb_div5_serial_checker.sv
// Directed bench for div5_serial_checker: reset, latency, backpressure,
// back-to-back accepts, mid-operation reset and a full 8-bit operand sweep.
module tb_div5_serial_checker;

   logic       clk;
   logic       rst_n;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] in_data;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_data;
   logic [2:0] out_rem;
   logic       out_div5;
   logic       busy;

   int unsigned n_total;
   int unsigned n_pass;

   div5_serial_checker #(.WIDTH(8), .CNT_W(6)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_rem   (out_rem),
      .out_div5  (out_div5),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
   endtask

   // Accept one operand, measure latency to out_valid, check the result and release it.
   task automatic run_op(input logic [7:0] val, input int unsigned exp_rem, input int unsigned stall);
      int unsigned lat;
      logic        stable;
      in_valid = 1'b1;
      in_data  = val;
      check("accept_ready", in_ready, 1);
      step();
      in_valid = 1'b0;
      in_data  = 8'hA5;
      check("busy_after_accept", {busy, in_ready}, 2'b10);
      lat = 0;
      while (!out_valid && lat < 40) begin
         step();
         lat++;
      end
      check("latency", lat, 8);
      stable = 1'b1;
      for (int i = 0; i < int'(stall); i++) begin
         step();
         if (!(out_valid && !in_ready && out_data == val && out_rem == 3'(exp_rem))) stable = 1'b0;
      end
      check("stall_stable", stable, 1);
      check("rem", out_rem, exp_rem);
      check("div5", out_div5, (exp_rem == 0) ? 1 : 0);
      check("data", out_data, val);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      check("release", {out_valid, in_ready, busy}, 3'b010);
   endtask

   initial begin
      int unsigned acc_cyc[3];
      int unsigned res_rem[3];
      int unsigned res_div[3];
      int unsigned na;
      int unsigned nr;
      int unsigned cyc;
      logic        acc;
      logic [7:0]  bb_vals[3];
      logic        bp_ok;
      int unsigned seen;

      n_total   = 0;
      n_pass    = 0;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b0;
      step();
      step();
      rst_n = 1'b1;
      check("reset_in_ready", in_ready, 1);
      check("reset_out_valid", out_valid, 0);
      check("reset_out_data", out_data, 0);
      check("reset_out_rem", out_rem, 0);
      check("reset_out_div5", out_div5, 0);
      check("reset_busy", busy, 0);

      run_op(8'd0,   0, 0);
      run_op(8'd255, 0, 0);
      run_op(8'd254, 4, 0);
      run_op(8'd7,   2, 0);
      run_op(8'd128, 3, 0);

      // Backpressure: hold the result for 20 cycles
      run_op(8'd13, 3, 20);
      check("hold_after_idle_rem", out_rem, 3);
      check("hold_after_idle_data", out_data, 13);

      // out_ready in IDLE has no effect
      out_ready = 1'b1;
      step();
      step();
      out_ready = 1'b0;
      check("idle_out_ready", {out_valid, in_ready}, 2'b01);

      // Back-to-back with in_valid held and out_ready tied high
      bb_vals[0] = 8'd10;
      bb_vals[1] = 8'd11;
      bb_vals[2] = 8'd12;
      na  = 0;
      nr  = 0;
      cyc = 0;
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_data   = bb_vals[0];
      while (nr < 3 && cyc < 80) begin
         acc = in_valid && in_ready;
         if (acc && na < 3) begin
            acc_cyc[na] = cyc;
            na++;
         end else if (acc) begin
            na++;
         end
         if (out_valid && nr < 3) begin
            res_rem[nr] = out_rem;
            res_div[nr] = out_div5;
            nr++;
         end
         step();
         cyc++;
         if (acc) begin
            if (na < 3) in_data = bb_vals[na];
            else in_valid = 1'b0;
         end
      end
      in_valid  = 1'b0;
      out_ready = 1'b0;
      check("bb_accepts", na, 3);
      check("bb_results", nr, 3);
      check("bb_gap01", acc_cyc[1] - acc_cyc[0], 10);
      check("bb_gap12", acc_cyc[2] - acc_cyc[1], 10);
      check("bb_res0", {res_div[0][0], res_rem[0][2:0]}, 4'b1_000);
      check("bb_res1", {res_div[1][0], res_rem[1][2:0]}, 4'b0_001);
      check("bb_res2", {res_div[2][0], res_rem[2][2:0]}, 4'b0_010);
      step();
      step();
      check("bb_idle", {out_valid, in_ready}, 2'b01);

      // Reset after 4 shift edges discards the operand
      in_valid = 1'b1;
      in_data  = 8'd99;
      step();
      in_valid = 1'b0;
      for (int i = 0; i < 4; i++) step();
      check("mid_busy", busy, 1);
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      check("mid_reset_state", {out_valid, in_ready, busy}, 3'b010);
      seen = 0;
      for (int i = 0; i < 12; i++) begin
         step();
         if (out_valid) seen++;
      end
      check("mid_no_output", seen, 0);
      run_op(8'd100, 0, 0);

      // Full sweep with random stalls
      seen  = 0;
      bp_ok = 1'b1;
      for (int v = 0; v < 256; v++) begin
         run_op(8'(v), v % 5, $urandom_range(0, 3));
         seen++;
      end
      check("sweep_count", seen, 256);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
